div_ctrl: RTL

- Multi-cycle divide sequencer for the EX stage of the 5-stage MIPS pipeline.
- Accepts DIV/DIVU operands from EX and runs a one-bit-per-cycle restoring divide on an internal shift/subtract datapath.
- Asserts a stall request into the pipeline stall controller while busy.
- Delivers {remainder, quotient} for the HI/LO write.

---
 rtl/div_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divide sequencer for the MIPS EX stage.
// Produces one quotient bit per cycle and requests a pipeline stall while EX waits.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  state_t             state_r;
  state_t             nxt_state_s;
  logic               accept_s;
  logic               iter_s;
  logic               last_s;
  logic               zero_s;
  logic               clear_s;

  logic [WIDTH-1:0]   dvd_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   rem_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_q_r;
  logic               neg_rem_r;
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     diff_s;
  logic               ge_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  assign a_neg_s = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg_s = signed_div_i & opdata2_i[WIDTH-1];

  // Trial subtract: |diff| < 2^WIDTH always, so its top bit is a true sign.
  assign shifted_s = {rem_r, dvd_r[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, dvs_r};
  assign ge_s      = ~diff_s[WIDTH];
  assign rem_nxt_s = ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
  assign quo_nxt_s = {dvd_r[WIDTH-2:0], ge_s};
  assign quo_fix_s = neg_q_r ? neg_f(quo_nxt_s) : quo_nxt_s;
  assign rem_fix_s = neg_rem_r ? neg_f(rem_nxt_s) : rem_nxt_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    nxt_state_s = state_r;
    accept_s    = 1'b0;
    iter_s      = 1'b0;
    last_s      = 1'b0;
    zero_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          accept_s = 1'b1;
          if (opdata2_i == ZERO_W) begin
            nxt_state_s = ST_DIVZERO;
          end else begin
            nxt_state_s = ST_ON;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_DIVZERO: begin
        if (annul_i) begin
          nxt_state_s = ST_IDLE;
        end else begin
          zero_s      = 1'b1;
          nxt_state_s = ST_END;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          nxt_state_s = ST_IDLE;
        end else begin
          iter_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            last_s      = 1'b1;
            nxt_state_s = ST_END;
          end else begin
            nxt_state_s = ST_ON;
          end
        end
      end
      ST_END: begin
        if (annul_i || !start_i) begin
          clear_s     = 1'b1;
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_END;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture (as magnitudes) and the shift/subtract iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_r     <= ZERO_W;
      dvs_r     <= ZERO_W;
      rem_r     <= ZERO_W;
      cnt_r     <= CNT_ZERO;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (accept_s) begin
      dvd_r     <= a_neg_s ? neg_f(opdata1_i) : opdata1_i;
      dvs_r     <= b_neg_s ? neg_f(opdata2_i) : opdata2_i;
      rem_r     <= ZERO_W;
      cnt_r     <= CNT_ZERO;
      neg_q_r   <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
    end else if (iter_s) begin
      dvd_r     <= quo_nxt_s;
      rem_r     <= rem_nxt_s;
      cnt_r     <= cnt_r + CNT_ONE;
    end else begin
      cnt_r     <= cnt_r;
    end
  end

  // Registered result and ready; an abort leaves the result untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {(2*WIDTH){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      ready_r <= (nxt_state_s == ST_END);
      if (last_s) begin
        result_r <= {rem_fix_s, quo_fix_s};
      end else if (zero_s || clear_s) begin
        result_r <= {(2*WIDTH){1'b0}};
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign result_o   = result_r;
  assign ready_o    = ready_r;
  assign stallreq_o = start_i & ~ready_r;

endmodule
